// File: rtl/feature_accum_if.sv
// Feature-in / sum-out handshake bundle between tree search, feature_accum and the next stage.
interface feature_accum_if #(
  parameter int DATA_WIDTH     = 16,
  parameter int DATA_BUS_WIDTH = 64,
  parameter int FEATURE_LENTH  = 9
);
  logic [DATA_BUS_WIDTH-1:0]           feat_in;
  logic                                feat_in_valid;
  logic                                feat_in_ready;
  logic [FEATURE_LENTH*DATA_WIDTH-1:0] sum_out;
  logic                                sum_valid;
  logic                                sum_ready;

  modport master (
    output feat_in, feat_in_valid, sum_ready,
    input  feat_in_ready, sum_out, sum_valid
  );

  modport slave (
    input  feat_in, feat_in_valid, sum_ready,
    output feat_in_ready, sum_out, sum_valid
  );
endinterface

// File: rtl/feature_accum.sv
// Element-wise saturating accumulator of packed 16-bit feature vectors.
// Features arrive as WORDS_PER_FEAT bus words; the summed vector leaves on a valid/ready port.
module feature_accum #(
  parameter int DATA_WIDTH     = 16,
  parameter int DATA_BUS_WIDTH = 64,
  parameter int FEATURE_LENTH  = 9,
  parameter int WORDS_PER_FEAT = 3,
  parameter int COUNT_WIDTH    = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [COUNT_WIDTH-1:0] feat_num,
  feature_accum_if.slave         bus,
  output logic                   busy,
  output logic                   overflow
);
  localparam int LANES  = DATA_BUS_WIDTH / DATA_WIDTH;
  localparam int WIDX_W = (WORDS_PER_FEAT > 1) ? $clog2(WORDS_PER_FEAT) : 1;
  localparam logic [WIDX_W-1:0] LAST_WORD = WIDX_W'(WORDS_PER_FEAT - 1);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_ACC = 2'd1, S_OUT = 2'd2} state_t;

  state_t                   state_q;
  logic [DATA_WIDTH-1:0]    acc_q [FEATURE_LENTH];
  logic [DATA_WIDTH-1:0]    acc_d [FEATURE_LENTH];
  logic                     ovf_d;
  logic [WIDX_W-1:0]        word_idx_q;
  logic [COUNT_WIDTH-1:0]   feat_idx_q;
  logic [COUNT_WIDTH-1:0]   feat_num_q;
  logic                     feat_in_ready_q;
  logic                     sum_valid_q;
  logic                     busy_q;
  logic                     overflow_q;
  logic [FEATURE_LENTH*DATA_WIDTH-1:0] sum_d;

  // Returns {clamped, result}; clamp to the signed extreme when the 17-bit sum leaves the 16-bit range.
  function automatic logic [DATA_WIDTH:0] sat_add(input logic [DATA_WIDTH-1:0] a,
                                                  input logic [DATA_WIDTH-1:0] b);
    logic [DATA_WIDTH:0] s;
    s = {a[DATA_WIDTH-1], a} + {b[DATA_WIDTH-1], b};
    if (s[DATA_WIDTH] != s[DATA_WIDTH-1]) begin
      if (s[DATA_WIDTH]) begin
        sat_add = {1'b1, 1'b1, {(DATA_WIDTH-1){1'b0}}};
      end else begin
        sat_add = {1'b1, 1'b0, {(DATA_WIDTH-1){1'b1}}};
      end
    end else begin
      sat_add = {1'b0, s[DATA_WIDTH-1:0]};
    end
  endfunction

  // Candidate accumulator values for the word at the input; only the elements of word_idx_q move.
  always_comb begin
    logic [DATA_WIDTH:0] r;
    ovf_d = 1'b0;
    r     = '0;
    for (int e = 0; e < FEATURE_LENTH; e++) begin
      if (word_idx_q == WIDX_W'(e / LANES)) begin
        r        = sat_add(acc_q[e], bus.feat_in[(e % LANES)*DATA_WIDTH +: DATA_WIDTH]);
        acc_d[e] = r[DATA_WIDTH-1:0];
        ovf_d    = ovf_d | r[DATA_WIDTH];
      end else begin
        acc_d[e] = acc_q[e];
      end
    end
  end

  // Flatten accumulators onto the output vector, element 0 in the low bits.
  always_comb begin
    sum_d = '0;
    for (int e = 0; e < FEATURE_LENTH; e++) begin
      sum_d[e*DATA_WIDTH +: DATA_WIDTH] = acc_q[e];
    end
  end

  // Job FSM with registered handshake, status and accumulator state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= S_IDLE;
      word_idx_q      <= '0;
      feat_idx_q      <= '0;
      feat_num_q      <= '0;
      feat_in_ready_q <= 1'b0;
      sum_valid_q     <= 1'b0;
      busy_q          <= 1'b0;
      overflow_q      <= 1'b0;
      for (int e = 0; e < FEATURE_LENTH; e++) acc_q[e] <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            feat_num_q <= feat_num;
            word_idx_q <= '0;
            feat_idx_q <= '0;
            overflow_q <= 1'b0;
            busy_q     <= 1'b1;
            for (int e = 0; e < FEATURE_LENTH; e++) acc_q[e] <= '0;
            if (feat_num == '0) begin
              state_q     <= S_OUT;
              sum_valid_q <= 1'b1;
            end else begin
              state_q         <= S_ACC;
              feat_in_ready_q <= 1'b1;
            end
          end
        end
        S_ACC: begin
          // feat_in_ready_q is constantly high here, so valid alone marks an accepted word.
          if (bus.feat_in_valid) begin
            for (int e = 0; e < FEATURE_LENTH; e++) acc_q[e] <= acc_d[e];
            overflow_q <= overflow_q | ovf_d;
            if (word_idx_q == LAST_WORD) begin
              word_idx_q <= '0;
              feat_idx_q <= feat_idx_q + COUNT_WIDTH'(1);
              if (feat_idx_q == feat_num_q - COUNT_WIDTH'(1)) begin
                state_q         <= S_OUT;
                feat_in_ready_q <= 1'b0;
                sum_valid_q     <= 1'b1;
              end
            end else begin
              word_idx_q <= word_idx_q + WIDX_W'(1);
            end
          end
        end
        S_OUT: begin
          if (bus.sum_ready) begin
            state_q     <= S_IDLE;
            sum_valid_q <= 1'b0;
            busy_q      <= 1'b0;
          end
        end
        default: begin
          state_q         <= S_IDLE;
          feat_in_ready_q <= 1'b0;
          sum_valid_q     <= 1'b0;
          busy_q          <= 1'b0;
        end
      endcase
    end
  end

  assign bus.feat_in_ready = feat_in_ready_q;
  assign bus.sum_valid     = sum_valid_q;
  assign bus.sum_out       = sum_d;
  assign busy              = busy_q;
  assign overflow          = overflow_q;
endmodule

// File: tb/tb_feature_accum.sv
// Directed bench for feature_accum: table of single-feature-repeated jobs plus hand sequences.
module tb_feature_accum;
  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [7:0]   feat_num;
  logic         busy;
  logic         overflow;
  int           errors = 0;
  int           checks = 0;

  feature_accum_if bus_if ();

  feature_accum dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .feat_num (feat_num),
    .bus      (bus_if),
    .busy     (busy),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]   num;
    logic [63:0]  w0;
    logic [63:0]  w1;
    logic [63:0]  w2;
    int           gap;
    logic [143:0] exp_sum;
    logic         exp_ovf;
  } vec_t;

  vec_t vecs [7];

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chkv(input string name, input logic [143:0] act, input logic [143:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Pulse start for one cycle; returns at the negedge after the accepting edge.
  task automatic do_start(input logic [7:0] n);
    @(negedge clk);
    start    = 1'b1;
    feat_num = n;
    @(negedge clk);
    start    = 1'b0;
    feat_num = 8'd0;
  endtask

  // Send n copies of a 3-word feature with gap idle cycles between words.
  task automatic send_words(input logic [7:0] n, input logic [63:0] w0, input logic [63:0] w1,
                            input logic [63:0] w2, input int gap, input string tag);
    logic [63:0] w [3];
    w[0] = w0; w[1] = w1; w[2] = w2;
    for (int f = 0; f < int'(n); f++) begin
      for (int k = 0; k < 3; k++) begin
        bus_if.feat_in       = w[k];
        bus_if.feat_in_valid = 1'b1;
        chk1({tag, " ready_in_acc"}, bus_if.feat_in_ready, 1'b1);
        chk1({tag, " no_early_valid"}, bus_if.sum_valid, 1'b0);
        @(negedge clk);
        bus_if.feat_in_valid = 1'b0;
        bus_if.feat_in       = 64'h5A5A_A5A5_1234_8765;
        if (!(f == int'(n) - 1 && k == 2)) begin
          for (int g = 0; g < gap; g++) begin
            @(negedge clk);
          end
        end
      end
    end
  endtask

  // Check the result one cycle after the last word, then complete the handshake.
  task automatic finish_job(input logic [143:0] exp_sum, input logic exp_ovf, input string tag);
    chk1({tag, " sum_valid_latency"}, bus_if.sum_valid, 1'b1);
    chkv({tag, " sum_out"}, bus_if.sum_out, exp_sum);
    chk1({tag, " overflow"}, overflow, exp_ovf);
    chk1({tag, " ready_low_out"}, bus_if.feat_in_ready, 1'b0);
    chk1({tag, " busy_out"}, busy, 1'b1);
    bus_if.sum_ready = 1'b1;
    @(negedge clk);
    bus_if.sum_ready = 1'b0;
    chk1({tag, " valid_drop"}, bus_if.sum_valid, 1'b0);
    chk1({tag, " busy_drop"}, busy, 1'b0);
    chk1({tag, " ovf_held"}, overflow, exp_ovf);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk1({tag, " ready"}, bus_if.feat_in_ready, 1'b0);
    chk1({tag, " valid"}, bus_if.sum_valid, 1'b0);
    chkv({tag, " sum"}, bus_if.sum_out, 144'd0);
    chk1({tag, " busy"}, busy, 1'b0);
    chk1({tag, " ovf"}, overflow, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [143:0] e1;
    e1 = {16'd9, 16'd8, 16'd7, 16'd6, 16'd5, 16'd4, 16'd3, 16'd2, 16'd1};
    vecs[0] = '{8'd1, 64'h0004_0003_0002_0001, 64'h0008_0007_0006_0005, 64'hFFFF_FFFF_FFFF_0009,
                0, e1, 1'b0};
    vecs[1] = '{8'd3, 64'h0004_0003_0002_0001, 64'h0008_0007_0006_0005, 64'hFFFF_FFFF_FFFF_0009,
                2, {16'd27, 16'd24, 16'd21, 16'd18, 16'd15, 16'd12, 16'd9, 16'd6, 16'd3}, 1'b0};
    vecs[2] = '{8'd2, {4{16'h7000}}, {4{16'h7000}}, {4{16'h7000}}, 0, {9{16'h7FFF}}, 1'b1};
    vecs[3] = '{8'd2, {4{16'h9000}}, {4{16'h9000}}, {4{16'h9000}}, 1, {9{16'h8000}}, 1'b1};
    vecs[4] = '{8'd1, {4{16'h0100}}, {4{16'h0100}}, {4{16'h0100}}, 0, {9{16'h0100}}, 1'b0};
    vecs[5] = '{8'd2, 64'hC000_3FFF_C000_3FFF, 64'hC000_3FFF_C000_3FFF, 64'hC000_3FFF_C000_3FFF, 0,
                {16'h7FFE, 16'h8000, 16'h7FFE, 16'h8000, 16'h7FFE, 16'h8000, 16'h7FFE, 16'h8000, 16'h7FFE},
                1'b0};
    vecs[6] = '{8'd4, {4{16'hFFFF}}, {4{16'hFFFF}}, 64'h7FFF_7FFF_7FFF_FFFF, 0, {9{16'hFFFC}}, 1'b0};

    rst = 1'b1; start = 1'b0; feat_num = 8'd0;
    bus_if.feat_in = 64'd0; bus_if.feat_in_valid = 1'b0; bus_if.sum_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_outputs("reset");
    rst = 1'b0;
    @(negedge clk);
    chk_reset_outputs("post_reset");

    for (int i = 0; i < 7; i++) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      do_start(vecs[i].num);
      chk1({tag, " busy_start"}, busy, 1'b1);
      send_words(vecs[i].num, vecs[i].w0, vecs[i].w1, vecs[i].w2, vecs[i].gap, tag);
      finish_job(vecs[i].exp_sum, vecs[i].exp_ovf, tag);
    end

    // feat_num = 0: immediate zero result; valid on the feature port must not be accepted.
    bus_if.feat_in_valid = 1'b1;
    bus_if.feat_in = 64'h0001_0001_0001_0001;
    do_start(8'd0);
    chk1("zero ready", bus_if.feat_in_ready, 1'b0);
    @(negedge clk);
    chk1("zero ready_hold", bus_if.feat_in_ready, 1'b0);
    bus_if.feat_in_valid = 1'b0;
    finish_job(144'd0, 1'b0, "zero");

    // Backpressure: hold sum_ready low while poking start and feat_in_valid.
    do_start(8'd1);
    send_words(8'd1, vecs[0].w0, vecs[0].w1, vecs[0].w2, 0, "bp");
    for (int c = 0; c < 5; c++) begin
      chk1("bp valid_held", bus_if.sum_valid, 1'b1);
      chkv("bp sum_stable", bus_if.sum_out, vecs[0].exp_sum);
      chk1("bp ready_low", bus_if.feat_in_ready, 1'b0);
      start = 1'b1; feat_num = 8'd5;
      bus_if.feat_in_valid = 1'b1; bus_if.feat_in = {4{16'h0011}};
      @(negedge clk);
    end
    start = 1'b0; feat_num = 8'd0; bus_if.feat_in_valid = 1'b0;
    finish_job(vecs[0].exp_sum, 1'b0, "bp");
    @(negedge clk);
    chk1("bp idle_busy", busy, 1'b0);
    chk1("bp idle_ready", bus_if.feat_in_ready, 1'b0);

    // Reset mid-job after 4 saturating words, then a clean job must show no residue.
    do_start(8'd2);
    for (int k = 0; k < 4; k++) begin
      bus_if.feat_in = {4{16'h7FFF}};
      bus_if.feat_in_valid = 1'b1;
      @(negedge clk);
    end
    bus_if.feat_in_valid = 1'b0;
    chk1("abort ovf_before_rst", overflow, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    chk_reset_outputs("mid_reset");
    rst = 1'b0;
    do_start(8'd1);
    send_words(8'd1, vecs[0].w0, vecs[0].w1, vecs[0].w2, 0, "fresh");
    finish_job(vecs[0].exp_sum, 1'b0, "fresh");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/feature_accum.md
# feature_accum

Downstream consumer of the tree search stage. It takes the 64-bit feature word stream emitted for each hit node and unpacks every FEATURE_LENTH-element feature, 16-bit signed per element. It accumulates a programmed number of features element-wise with saturation, then presents the summed feature vector to the next stage over a valid/ready handshake.

## Interface
Parameters:
- DATA_WIDTH, 16, element width; signed two's complement.
- DATA_BUS_WIDTH, 64, input word width; carries DATA_BUS_WIDTH/DATA_WIDTH = 4 lanes.
- FEATURE_LENTH, 9, elements per feature.
- WORDS_PER_FEAT, 3, input words per feature; equals ceil(FEATURE_LENTH*DATA_WIDTH/DATA_BUS_WIDTH).
- COUNT_WIDTH, 8, width of the feature-count field.

Ports:
- clk  in  1  sole clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle job start pulse; honoured only in IDLE.
- feat_num  in  COUNT_WIDTH  features to accumulate in this job; sampled with start.
- feat_in  in  DATA_BUS_WIDTH  feature word from tree search.
- feat_in_valid  in  1  feat_in is valid.
- feat_in_ready  out  1  block accepts a word this cycle.
- sum_out  out  FEATURE_LENTH*DATA_WIDTH  accumulated vector; element i at [i*DATA_WIDTH +: DATA_WIDTH].
- sum_valid  out  1  sum_out is valid.
- sum_ready  in  1  downstream accepts sum_out.
- busy  out  1  high in ACC and OUT.
- overflow  out  1  sticky; set if any addition in the current job saturated.

## Operation
- The FSM has three states: IDLE, ACC and OUT.
- IDLE:
  - feat_in_ready=0 and sum_valid=0.
  - On start: latch feat_num, clear all accumulators, clear overflow, set word_idx=0 and feat_idx=0.
  - Go to OUT if feat_num==0, otherwise go to ACC.
- ACC:
  - feat_in_ready=1.
  - A word is accepted when feat_in_valid && feat_in_ready.
  - Element mapping: element e = word_idx*4 + lane, taken from feat_in[lane*16 +: 16].
  - Only lanes with e < FEATURE_LENTH are added. For word_idx=2 only lane 0 (element 8) is added; lanes 1-3 are ignored.
  - Each addition is signed and saturating: results above 0x7FFF clamp to 0x7FFF, below 0x8000 clamp to 0x8000. Any clamp sets overflow.
  - word_idx counts 0→1→2→0 on accepted words. On an accepted word with word_idx==2, feat_idx increments.
  - When the accepted word has word_idx==2 and feat_idx==feat_num-1, go to OUT.
- OUT:
  - sum_valid=1 and sum_out=accumulators; both are registered and held stable.
  - feat_in_ready=0.
  - On sum_valid && sum_ready, go to IDLE. overflow holds its value until the next start.
- start is ignored in ACC and OUT.
- feat_in_valid is ignored outside ACC.

## Timing
- Reset values: feat_in_ready=0, sum_valid=0, sum_out=0, busy=0, overflow=0, FSM=IDLE, all counters and accumulators 0.
- rst asserted in any state returns every output to its reset value at the next edge. A partial job is discarded.
- Start accepted at edge T: busy=1 and feat_in_ready=1 from cycle T+1 (or sum_valid=1 from T+1 if feat_num==0).
- Throughput is one word per cycle, i.e. one feature per 3 cycles under continuous valid.
- Latency: last word accepted at edge N gives sum_valid=1 in cycle N+1. The accumulator update and sum_out are visible at the same time.
- Handshake rules:
  - feat_in_ready does not depend combinationally on feat_in_valid.
  - sum_valid does not depend on sum_ready.
  - Once sum_valid rises it stays high, with sum_out constant, until accepted.
- Handshake completing at edge M: sum_valid=0 and busy=0 in cycle M+1; a new start is accepted at edge M+1 at the earliest.
- feat_num=2^COUNT_WIDTH-1 (255): 765 words, no counter wrap.

## Test plan
- Single feature, feat_num=1, with words:
  - w0=0x0004_0003_0002_0001
  - w1=0x0008_0007_0006_0005
  - w2=0xFFFF_FFFF_FFFF_0009

  Required response: sum_out elements 0..8 = 1..9, sum_valid exactly one cycle after w2 is accepted, upper lanes of w2 ignored, overflow=0.
- feat_num=3 with the same feature sent three times, and feat_in_valid dropped for 2 cycles between words → elements = 3,6,...,27, with no word lost or duplicated.
- Saturation:
  - Job 1, feat_num=2, every element 0x7000 → every element 0x7FFF, overflow=1.
  - Job 2, every element 0x9000 → every element 0x8000.
  - Job 3, a non-saturating job → overflow=0.
- feat_num=0: start → sum_valid=1 the next cycle with sum_out=0, feat_in_ready never asserted.
- Backpressure: hold sum_ready=0 for 5 cycles while pulsing start and driving feat_in_valid → sum_out stable, feat_in_ready=0, start ignored; raise sum_ready → IDLE next cycle, busy=0.
- Reset mid-job: assert rst after 4 accepted words of a feat_num=2 job → all outputs 0 the next cycle. A fresh feat_num=1 job then produces the correct sum with no residue from the aborted job.
